// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Holds the FSM state encoding, the header tag and the grant-index width function.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_e;

    localparam logic [3:0] HDR_TAG = 4'hA;

    // Index width for n entries, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] header_byte(input logic [3:0] id);
        return {HDR_TAG, id};
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester byte streams plus the single uart send/done handshake.
// master = producers and uart side, slave = the scheduler.
interface uart_tx_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               uart_send;
    logic [7:0]         uart_data;
    logic               uart_done;

    modport master (
        output req_valid, req_data, req_last, uart_done,
        input  req_ready, uart_send, uart_data
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_done,
        output req_ready, uart_send, uart_data
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr+1, modulo N_REQ.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any
);

    logic [ID_W-1:0] idx_s;

    // Scan from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx_s = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx_s = ID_W'((int'(ptr) + i) % N_REQ);
            if (req[idx_s]) begin
                grant = idx_s;
                any   = 1'b1;
            end else begin
                any   = any;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart byte transmitter among N_REQ packet sources,
// with optional source-ID header byte and an acknowledge timeout.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HEADER_EN   = 1,
    parameter int ACK_TIMEOUT = 16,
    localparam int ID_W       = id_width(N_REQ)
) (
    input  logic                clock,
    input  logic                reset_n,
    uart_tx_scheduler_if.slave  bus,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id,
    output logic                timeout_err
);

    localparam int CNT_W = id_width(ACK_TIMEOUT);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    sched_state_e     state_r, state_nxt_s;
    logic             uart_send_r, uart_send_nxt_s;
    logic [7:0]       uart_data_r, uart_data_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic [ID_W-1:0]  grant_r, grant_nxt_s;
    logic [ID_W-1:0]  ptr_r, ptr_nxt_s;
    logic [N_REQ-1:0] req_ready_r, req_ready_nxt_s;
    logic             timeout_r, timeout_nxt_s;
    logic             last_r, last_nxt_s;
    logic             hdr_r, hdr_nxt_s;
    logic             seen_idle_r, seen_idle_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    logic [ID_W-1:0]  arb_grant_s;
    logic             arb_any_s;
    logic             hs_s;
    logic [7:0]       byte_s;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .any   (arb_any_s)
    );

    assign hs_s   = bus.req_valid[grant_r] & req_ready_r[grant_r];
    assign byte_s = bus.req_data[{grant_r, 3'b000} +: 8];

    // Next-state and next-output decode for the per-packet byte sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        uart_send_nxt_s = uart_send_r;
        uart_data_nxt_s = uart_data_r;
        busy_nxt_s      = busy_r;
        grant_nxt_s     = grant_r;
        ptr_nxt_s       = ptr_r;
        timeout_nxt_s   = 1'b0;
        last_nxt_s      = last_r;
        hdr_nxt_s       = hdr_r;
        seen_idle_nxt_s = seen_idle_r;
        cnt_nxt_s       = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    grant_nxt_s = arb_grant_s;
                    busy_nxt_s  = 1'b1;
                    if (HEADER_EN != 0) begin
                        uart_data_nxt_s = header_byte(4'(arb_grant_s));
                        uart_send_nxt_s = 1'b1;
                        hdr_nxt_s       = 1'b1;
                        cnt_nxt_s       = '0;
                        // A uart already busy must go idle before its low counts as our ack.
                        seen_idle_nxt_s = bus.uart_done;
                        state_nxt_s     = ST_SEND;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hs_s) begin
                    uart_data_nxt_s = byte_s;
                    last_nxt_s      = bus.req_last[grant_r];
                    hdr_nxt_s       = 1'b0;
                    uart_send_nxt_s = 1'b1;
                    cnt_nxt_s       = '0;
                    seen_idle_nxt_s = bus.uart_done;
                    state_nxt_s     = ST_SEND;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_SEND: begin
                if (!bus.uart_done && seen_idle_r) begin
                    uart_send_nxt_s = 1'b0;
                    state_nxt_s     = ST_WAIT_DONE;
                end else if (cnt_r == CNT_W'(ACK_TIMEOUT - 1)) begin
                    uart_send_nxt_s = 1'b0;
                    timeout_nxt_s   = 1'b1;
                    busy_nxt_s      = 1'b0;
                    ptr_nxt_s       = grant_r;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    cnt_nxt_s       = cnt_r + CNT_W'(1);
                    seen_idle_nxt_s = seen_idle_r | bus.uart_done;
                    state_nxt_s     = ST_SEND;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.uart_done) begin
                    if (hdr_r || !last_r) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        ptr_nxt_s   = grant_r;
                        busy_nxt_s  = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Ready is a pure function of the next registered state and grantee.
        if (state_nxt_s == ST_LOAD) begin
            req_ready_nxt_s = ONE_HOT0 << grant_nxt_s;
        end else begin
            req_ready_nxt_s = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            uart_send_r <= 1'b0;
            uart_data_r <= 8'h00;
            busy_r      <= 1'b0;
            grant_r     <= '0;
            ptr_r       <= ID_W'(N_REQ - 1);
            req_ready_r <= '0;
            timeout_r   <= 1'b0;
            last_r      <= 1'b0;
            hdr_r       <= 1'b0;
            seen_idle_r <= 1'b0;
            cnt_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            uart_send_r <= uart_send_nxt_s;
            uart_data_r <= uart_data_nxt_s;
            busy_r      <= busy_nxt_s;
            grant_r     <= grant_nxt_s;
            ptr_r       <= ptr_nxt_s;
            req_ready_r <= req_ready_nxt_s;
            timeout_r   <= timeout_nxt_s;
            last_r      <= last_nxt_s;
            hdr_r       <= hdr_nxt_s;
            seen_idle_r <= seen_idle_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.uart_send = uart_send_r;
    assign bus.uart_data = uart_data_r;
    assign busy          = busy_r;
    assign grant_id      = grant_r;
    assign timeout_err   = timeout_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester queues and a uart model drive the DUT,
// a monitor pops expected bytes, timeouts and packet ends as the DUT presents them.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int TMO = 16;

    localparam int EV_BYTE = 0;
    localparam int EV_TMO  = 1;
    localparam int EV_END  = 2;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } beat_t;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         id;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       busy;
    logic [1:0] grant_id;
    logic       timeout_err;

    uart_tx_scheduler_if #(.N_REQ(N)) bus ();

    uart_tx_scheduler #(.N_REQ(N), .HEADER_EN(1), .ACK_TIMEOUT(TMO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    beat_t  rq [N][$];
    exp_t   sb [$];
    int     chk_cnt = 0;
    int     pass_cnt = 0;
    logic   stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        chk_cnt++;
        $display("FAIL %s: got no event, expected one at %0t", name, $time);
    endtask

    task automatic push_beat(input int r, input logic [7:0] d, input logic l, input int gap);
        beat_t b;
        b.data = d; b.last = l; b.gap = gap;
        rq[r].push_back(b);
    endtask

    task automatic exp_ev(input int kind, input logic [7:0] d, input int id);
        exp_t e;
        e.kind = kind; e.data = d; e.id = id;
        sb.push_back(e);
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clock);
            if (sb.size() == 0 && queues_empty() && !busy) ok = 1'b1;
        end
        if (!ok) fail_now(name);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_uart_send"}, 32'(bus.uart_send), 32'd0);
        check({tag, "_uart_data"}, 32'(bus.uart_data), 32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
        check({tag, "_grant_id"},  32'(grant_id),      32'd0);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_timeout"},   32'(timeout_err),   32'd0);
    endtask

    // Requester driver: pops accepted beats and presents the next one after an optional gap.
    logic [N-1:0] hs_pend = '0;
    int           hold [N];
    initial begin
        logic [N-1:0]   v;
        logic [8*N-1:0] d;
        logic [N-1:0]   l;
        for (int i = 0; i < N; i++) hold[i] = 0;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
        forever begin
            @(negedge clock);
            v = '0; d = '0; l = '0;
            for (int i = 0; i < N; i++) begin
                if (hs_pend[i] && rq[i].size() != 0) begin
                    hold[i] = rq[i][0].gap;
                    void'(rq[i].pop_front());
                end
                if (hold[i] > 0) begin
                    hold[i]--;
                end else if (rq[i].size() != 0) begin
                    v[i] = 1'b1;
                    d[8*i +: 8] = rq[i][0].data;
                    l[i] = rq[i][0].last;
                end
            end
            bus.req_valid = v; bus.req_data = d; bus.req_last = l;
            hs_pend = bus.req_valid & bus.req_ready;
        end
    end

    // uart model: takes a send when idle, holds done low for three cycles.
    initial begin
        int ubusy = 0;
        bus.uart_done = 1'b1;
        forever begin
            @(negedge clock);
            if (ubusy > 0) begin
                ubusy--;
                if (ubusy == 0) bus.uart_done = 1'b1;
            end else if (bus.uart_send && bus.uart_done && !stuck) begin
                bus.uart_done = 1'b0;
                ubusy = 3;
            end
        end
    end

    // Monitor: pops the scoreboard on every new send, timeout pulse and packet end.
    initial begin
        logic prev_send = 1'b0;
        logic prev_busy = 1'b0;
        int   high = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.uart_send && !prev_send) begin
                high = 1;
                if (sb.size() == 0) fail_now("unexpected_byte");
                else begin
                    e = sb.pop_front();
                    check("byte_kind", 32'(EV_BYTE), 32'(e.kind));
                    check("uart_data", 32'(bus.uart_data), 32'(e.data));
                    check("byte_grant", 32'(grant_id), 32'(e.id));
                end
            end else if (bus.uart_send) begin
                high++;
            end
            if (timeout_err) begin
                if (sb.size() == 0) fail_now("unexpected_timeout");
                else begin
                    e = sb.pop_front();
                    check("tmo_kind", 32'(EV_TMO), 32'(e.kind));
                    check("send_high_cycles", 32'(high), 32'(TMO));
                end
            end
            if (prev_busy && !busy) begin
                if (sb.size() == 0) fail_now("unexpected_end");
                else begin
                    e = sb.pop_front();
                    check("end_kind", 32'(EV_END), 32'(e.kind));
                    check("end_grant", 32'(grant_id), 32'(e.id));
                end
            end
            if (bus.req_ready != '0) begin
                check("ready_grantee_only", 32'(bus.req_ready), 32'(4'b0001 << grant_id));
            end
            prev_send = bus.uart_send;
            prev_busy = busy;
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        bit seen;
        repeat (3) @(negedge clock);
        check_reset_outputs("por");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Every requester valid, one-byte packets: grants 0,1,2,3,0,1,2,3.
        for (int i = 0; i < N; i++) begin
            push_beat(i, 8'h80 + 8'(i), 1'b1, 0);
            push_beat(i, 8'h90 + 8'(i), 1'b1, 0);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                exp_ev(EV_BYTE, 8'hA0 + 8'(i), i);
                exp_ev(EV_BYTE, 8'h80 + 8'(16 * r + i), i);
                exp_ev(EV_END, 8'h00, i);
            end
        end
        wait_drain("rr_drain");

        // Single requester 2.
        push_beat(2, 8'h55, 1'b0, 0);
        push_beat(2, 8'h3C, 1'b1, 0);
        exp_ev(EV_BYTE, 8'hA2, 2); exp_ev(EV_BYTE, 8'h55, 2); exp_ev(EV_BYTE, 8'h3C, 2);
        exp_ev(EV_END, 8'h00, 2);
        wait_drain("single_drain");

        // Two 3-byte packets, no interleaving.
        push_beat(0, 8'h01, 1'b0, 0); push_beat(0, 8'h02, 1'b0, 0); push_beat(0, 8'h03, 1'b1, 0);
        push_beat(1, 8'h11, 1'b0, 0); push_beat(1, 8'h12, 1'b0, 0); push_beat(1, 8'h13, 1'b1, 0);
        exp_ev(EV_BYTE, 8'hA0, 0); exp_ev(EV_BYTE, 8'h01, 0); exp_ev(EV_BYTE, 8'h02, 0);
        exp_ev(EV_BYTE, 8'h03, 0); exp_ev(EV_END, 8'h00, 0);
        exp_ev(EV_BYTE, 8'hA1, 1); exp_ev(EV_BYTE, 8'h11, 1); exp_ev(EV_BYTE, 8'h12, 1);
        exp_ev(EV_BYTE, 8'h13, 1); exp_ev(EV_END, 8'h00, 1);
        wait_drain("pair_drain");

        // Stuck uart: header of requester 2 times out, requester 3 goes next, then 2 again.
        stuck = 1'b1;
        push_beat(2, 8'h5A, 1'b1, 0);
        push_beat(3, 8'h6B, 1'b1, 0);
        exp_ev(EV_BYTE, 8'hA2, 2); exp_ev(EV_TMO, 8'h00, 2); exp_ev(EV_END, 8'h00, 2);
        exp_ev(EV_BYTE, 8'hA3, 3); exp_ev(EV_BYTE, 8'h6B, 3); exp_ev(EV_END, 8'h00, 3);
        exp_ev(EV_BYTE, 8'hA2, 2); exp_ev(EV_BYTE, 8'h5A, 2); exp_ev(EV_END, 8'h00, 2);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (timeout_err) seen = 1'b1;
        end
        if (!seen) fail_now("timeout_pulse");
        stuck = 1'b0;
        wait_drain("timeout_drain");

        // Grantee 0 drops valid for 20 cycles mid-packet while requester 1 waits.
        push_beat(0, 8'hC1, 1'b0, 20);
        push_beat(0, 8'hC2, 1'b1, 0);
        push_beat(1, 8'hD1, 1'b1, 0);
        exp_ev(EV_BYTE, 8'hA0, 0); exp_ev(EV_BYTE, 8'hC1, 0); exp_ev(EV_BYTE, 8'hC2, 0);
        exp_ev(EV_END, 8'h00, 0);
        exp_ev(EV_BYTE, 8'hA1, 1); exp_ev(EV_BYTE, 8'hD1, 1); exp_ev(EV_END, 8'h00, 1);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (!bus.req_valid[0] && bus.req_ready[0]) seen = 1'b1;
        end
        if (!seen) fail_now("hold_wait");
        repeat (10) @(negedge clock);
        check("hold_ready", 32'(bus.req_ready), 32'h1);
        check("hold_grant", 32'(grant_id), 32'h0);
        check("hold_busy", 32'(busy), 32'h1);
        wait_drain("hold_drain");

        // Reset during WAIT_DONE of requester 1's first data byte.
        push_beat(1, 8'hE1, 1'b0, 0);
        push_beat(1, 8'hE2, 1'b1, 0);
        exp_ev(EV_BYTE, 8'hA1, 1); exp_ev(EV_BYTE, 8'hE1, 1);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (bus.uart_data == 8'hE1 && !bus.uart_send) seen = 1'b1;
        end
        if (!seen) fail_now("reset_wait");
        reset_n = 1'b0;
        push_beat(0, 8'hF0, 1'b1, 0);
        exp_ev(EV_END, 8'h00, 0);
        exp_ev(EV_BYTE, 8'hA0, 0); exp_ev(EV_BYTE, 8'hF0, 0); exp_ev(EV_END, 8'h00, 0);
        exp_ev(EV_BYTE, 8'hA1, 1); exp_ev(EV_BYTE, 8'hE2, 1); exp_ev(EV_END, 8'h00, 1);
        @(negedge clock);
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        wait_drain("reset_drain");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Global bound on simulation time.
    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one `uart` byte transmitter among `N_REQ` byte-stream requesters. It grants the transmitter to one requester per packet, optionally prefixes each packet with a source-ID header byte, and sequences the `uart` send/done handshake for every byte. A timeout recovers from a transmitter that never acknowledges. It sits between the logging/telemetry producers and the single `uart` instance driving the board TX pin.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `HEADER_EN`, default 1: 1 = send header byte `{4'hA, id[3:0]}` before each packet.
- `ACK_TIMEOUT`, default 16: maximum cycles `uart_send` may stay high without `uart_done` falling.

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset, sampled on `clock`.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in 8*N_REQ: requester i byte at `[8i+7:8i]`.
- `req_last` in N_REQ: the byte is the last of the packet.
- `req_ready` out N_REQ: byte accepted when `req_valid[i] && req_ready[i]`.
- `uart_send` out 1: send request to `uart`.
- `uart_data` out 8: byte to `uart`, held stable while `uart_send`=1.
- `uart_done` in 1: `uart` idle/ready (high = idle).
- `busy` out 1: a packet is in progress.
- `grant_id` out clog2(N_REQ): current or most recent grantee.
- `timeout_err` out 1: one-cycle pulse on ack timeout.

## Operation
- States: IDLE, LOAD, SEND, WAIT_DONE.
- Reset values: `uart_send`=0, `uart_data`=0, `busy`=0, `grant_id`=0, `req_ready`=0, `timeout_err`=0, state IDLE. The round-robin pointer resets to N_REQ-1, so requester 0 has first priority.
- IDLE: if any `req_valid` is high, pick the first requester at or after pointer+1 (modulo N_REQ). Register `grant_id` and set `busy`=1.
  - With HEADER_EN=1: load `uart_data`=`{4'hA, grant_id}`, set `uart_send`=1, go to SEND.
  - With HEADER_EN=0: go to LOAD.
- LOAD: `req_ready[grant_id]`=1, decoded from registered state only, with no combinational path from `req_valid`.
  - On a handshake, capture the byte and the `last` flag, load `uart_data`, set `uart_send`=1, go to SEND.
  - If the grantee drops `req_valid`, wait indefinitely. The packet is never interleaved with another requester.
- SEND: hold `uart_send`=1. When `uart_done`=0 is sampled, deassert `uart_send` and go to WAIT_DONE.
- WAIT_DONE: wait for `uart_done`=1.
  - Then, if the byte was the header or was not last, go to LOAD.
  - If the byte was last: set pointer=`grant_id`, `busy`=0, go to IDLE.
- Timeout: a counter runs in SEND and clears on entry.
  - When it reaches ACK_TIMEOUT with `uart_done` still 1: deassert `uart_send`, pulse `timeout_err`, abort the packet (`busy`=0, pointer=`grant_id`), go to IDLE.
  - The remaining bytes of the aborted packet arrive later as a new packet.
- Only the grantee may see `req_ready`. All other `req_ready` bits stay 0.

## Timing
- Idle grant: `req_valid` seen in cycle 0, then `grant_id`/`busy` valid in cycle 1, then `uart_send`=1 in cycle 1 (header) or `req_ready` in cycle 1 (no header).
- A LOAD handshake in cycle k gives `uart_send`=1 in cycle k+1.
- `uart_send` falls the cycle after `uart_done`=0 is sampled.
- At most one byte is in flight. The next LOAD is entered the cycle after `uart_done` returns high.
- Simultaneous valids: strict round-robin per packet. The last grantee has lowest priority next.
- `reset_n` low mid-packet: all outputs return to reset values on the next edge. The partially sent byte is dropped.
- `uart_done` already low in IDLE: SEND waits, bounded by the timeout.

## Structure
- Package `uart_sched_pkg` holds the state enum, `HDR_TAG`=4'hA, and the width function for `grant_id`.
- Sub-module `rr_arbiter`: combinational round-robin picker with inputs request vector and pointer, outputs grant index and `any`.

## Test plan
- Single requester, HEADER_EN=1, requester 2 sends 0x55, 0x3C(last) -> `uart_data` sequence 0xA2, 0x55, 0x3C, each with one send/done handshake; `busy` falls after 0x3C.
- Requesters 0 and 1 both valid with 3-byte packets -> packet 0 completes uninterrupted, then packet 1; `grant_id` goes 0 then 1, with no interleaving.
- All four requesters continuously valid, one-byte packets -> grant order 0,1,2,3,0.
- `uart_done` stuck high, ACK_TIMEOUT=16 -> `uart_send` high for exactly 16 cycles, one `timeout_err` pulse, state IDLE, next requester granted.
- Grantee drops `req_valid` for 20 cycles mid-packet while others are valid -> scheduler waits with `req_ready` on the grantee only, then resumes the same packet.
- `reset_n` low during WAIT_DONE -> next cycle all outputs at reset values; the following grant goes to requester 0.
